// File: rtl/m_clk_ctrl.sv
// m_clk_ctrl: programmable clock-enable generator.
// After a start pulse it issues a one-cycle r_tick every w_div clocks and
// toggles r_phase on each tick. It counts ticks in r_cnt and stops in DONE
// once w_limit ticks have been issued (w_limit = 0 means free-run).
// Optional feature macro: CLK_CTRL_PAUSE_EN adds the w_pause hold input.
// r_state exposes the FSM encoding (IDLE=0, RUN=1, DONE=2) for debug.
//
// Handshake: w_start and w_stop are single-cycle request pulses sampled on
// the rising edge of w_clk. There is no ready/acknowledge. A start is taken
// only in IDLE or DONE. A stop is taken only in RUN and wins over a start
// in the same cycle.
//
// Tick timing: r_tick is a register. It is high during the RUN cycle in
// which the divider counter holds div-1. The count and phase update on the
// edge that closes that cycle, and the limit check happens on that same
// edge.
module m_clk_ctrl #(
  parameter int DIVW = 8,
  parameter int CNTW = 16
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic            w_start,
  input  logic            w_stop,
  input  logic [DIVW-1:0] w_div,
  input  logic [CNTW-1:0] w_limit,
`ifdef CLK_CTRL_PAUSE_EN
  input  logic            w_pause,
`endif
  output logic            r_tick,
  output logic            r_phase,
  output logic [CNTW-1:0] r_cnt,
  output logic            r_busy,
  output logic            r_done,
  output logic [1:0]      r_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [DIVW-1:0] DIV_ONE = {{(DIVW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [DIVW-1:0] div_cnt;
  logic [DIVW-1:0] div_l;
  logic [CNTW-1:0] limit_l;

  logic [DIVW-1:0] div_start;
  logic [DIVW-1:0] div_last;
  logic [DIVW-1:0] div_nxt;
  logic [CNTW-1:0] cnt_nxt;
  logic            limit_hit;
  logic            pause_act;

`ifdef CLK_CTRL_PAUSE_EN
  assign pause_act = w_pause;
`else
  assign pause_act = 1'b0;
`endif

  assign r_busy  = (state == ST_RUN);
  assign r_done  = (state == ST_DONE);
  assign r_state = state;

  // Next divider value, normalised start ratio, and the limit test for the
  // tick that is being issued in the current cycle.
  always_comb begin
    div_start = (w_div == '0) ? DIV_ONE : w_div;
    div_last  = div_l - DIV_ONE;
    div_nxt   = (div_cnt == div_last) ? '0 : (div_cnt + DIV_ONE);
    cnt_nxt   = r_cnt + CNT_ONE;
    limit_hit = r_tick && (limit_l != '0) && (cnt_nxt == limit_l);
  end

  // Control FSM together with the divider, tick, count and phase registers.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      div_l   <= DIV_ONE;
      limit_l <= '0;
      r_tick  <= 1'b0;
      r_phase <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (w_start && !w_stop) begin
            state   <= ST_RUN;
            div_l   <= div_start;
            limit_l <= w_limit;
            div_cnt <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            // A ratio of 1 ticks in the very first RUN cycle.
            r_tick  <= (div_start == DIV_ONE);
          end
        end
        ST_RUN: begin
          if (w_stop) begin
            state  <= ST_IDLE;
            r_tick <= 1'b0;
          end else begin
            if (r_tick) begin
              r_cnt   <= cnt_nxt;
              r_phase <= ~r_phase;
            end
            if (limit_hit) begin
              state  <= ST_DONE;
              r_tick <= 1'b0;
            end else if (pause_act) begin
              // Hold the divider where it is so release resumes seamlessly.
              r_tick <= 1'b0;
            end else begin
              div_cnt <= div_nxt;
              r_tick  <= (div_nxt == div_last);
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          r_tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_clk_ctrl.sv
// Testbench for m_clk_ctrl. It applies a table of start/limit/stop
// scenarios and compares the result of each one against hand-computed
// values. A queue holds the tick cycle numbers that each scenario should
// produce. Hand-written sequences cover reset, start/stop collisions,
// restart during RUN, stop in DONE and, when CLK_CTRL_PAUSE_EN is
// defined, pause.
module tb_m_clk_ctrl;

  logic        w_clk;
  logic        w_rst_n;
  logic        w_start;
  logic        w_stop;
  logic [7:0]  w_div;
  logic [15:0] w_limit;
`ifdef CLK_CTRL_PAUSE_EN
  logic        w_pause;
`endif
  logic        r_tick;
  logic        r_phase;
  logic [15:0] r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [1:0]  r_state;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  typedef struct {
    int div;
    int limit;
    int n;
    bit stop;
    int exp_cnt;
    bit exp_phase;
    bit exp_busy;
    bit exp_done;
  } vec_t;

  vec_t vecs[6];

  m_clk_ctrl #(.DIVW(8), .CNTW(16)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_start (w_start),
    .w_stop  (w_stop),
    .w_div   (w_div),
    .w_limit (w_limit),
`ifdef CLK_CTRL_PAUSE_EN
    .w_pause (w_pause),
`endif
    .r_tick  (r_tick),
    .r_phase (r_phase),
    .r_cnt   (r_cnt),
    .r_busy  (r_busy),
    .r_done  (r_done),
    .r_state (r_state)
  );

  // Clock and reset
  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare r_tick in RUN cycle k against the queue of expected tick cycles.
  task automatic check_tick(input int k);
    logic exp;
    exp = (exp_q.size() > 0) && (exp_q[0] == k);
    check($sformatf("tick_cycle_%0d", k), 32'(r_tick), 32'(exp));
    if (exp) void'(exp_q.pop_front());
  endtask

  // Pulse start at a negedge. Returns at the negedge inside RUN cycle 1.
  // Afterwards the ratio and limit inputs are scrambled, because the DUT
  // must have latched them and must ignore later changes.
  task automatic start_pulse(input int d, input int l);
    w_start = 1'b1;
    w_div   = 8'(d);
    w_limit = 16'(l);
    @(negedge w_clk);
    w_start = 1'b0;
    w_div   = 8'($urandom_range(0, 255));
    w_limit = 16'($urandom_range(0, 65535));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int d;
    int nt;
    d  = (v.div == 0) ? 1 : v.div;
    nt = 0;
    exp_q.delete();
    for (int k = 1; k <= v.n; k++) begin
      if ((k % d == 0) && (v.limit == 0 || nt < v.limit)) begin
        exp_q.push_back(32'(k));
        nt++;
      end
    end
    start_pulse(v.div, v.limit);
    for (int k = 1; k <= v.n; k++) begin
      check_tick(k);
      if (k == v.n && v.stop) w_stop = 1'b1;
      @(negedge w_clk);
      w_stop = 1'b0;
    end
    check($sformatf("v%0d_ticks_left", idx), 32'(exp_q.size()), 32'd0);
    check($sformatf("v%0d_cnt", idx), 32'(r_cnt), 32'(v.exp_cnt));
    check($sformatf("v%0d_phase", idx), 32'(r_phase), 32'(v.exp_phase));
    check($sformatf("v%0d_busy", idx), 32'(r_busy), 32'(v.exp_busy));
    check($sformatf("v%0d_done", idx), 32'(r_done), 32'(v.exp_done));
    for (int j = 0; j < 3; j++) begin
      check($sformatf("v%0d_hold_tick", idx), 32'(r_tick), 32'd0);
      check($sformatf("v%0d_hold_cnt", idx), 32'(r_cnt), 32'(v.exp_cnt));
      @(negedge w_clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    w_rst_n  = 1'b0;
    w_start  = 1'b0;
    w_stop   = 1'b0;
    w_div    = '0;
    w_limit  = '0;
`ifdef CLK_CTRL_PAUSE_EN
    w_pause  = 1'b0;
`endif

    //          div lim  n  stop cnt ph busy done
    vecs[0] = '{5,  8,  40, 1'b0, 8, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{0,  3,  3,  1'b0, 3, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{4,  0,  10, 1'b1, 2, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1,  5,  5,  1'b0, 5, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{3,  0,  7,  1'b1, 2, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{7,  1,  7,  1'b0, 1, 1'b1, 1'b0, 1'b1};

    // Reset state
    #1;
    check("rst_tick", 32'(r_tick), 32'd0);
    check("rst_busy", 32'(r_busy), 32'd0);
    check("rst_done", 32'(r_done), 32'd0);
    check("rst_cnt", 32'(r_cnt), 32'd0);
    check("rst_state", 32'(r_state), 32'd0);
    @(negedge w_clk);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    @(negedge w_clk);
    check("idle_busy", 32'(r_busy), 32'd0);

    // Table-driven scenarios
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Stop in DONE has no effect
    w_stop = 1'b1;
    @(negedge w_clk);
    w_stop = 1'b0;
    check("done_stop_done", 32'(r_done), 32'd1);
    check("done_stop_cnt", 32'(r_cnt), 32'd1);

    // Start and stop in the same cycle from DONE and from IDLE
    w_start = 1'b1; w_stop = 1'b1; w_div = 8'd1; w_limit = 16'd0;
    @(negedge w_clk);
    w_start = 1'b0; w_stop = 1'b0;
    check("startstop_done_busy", 32'(r_busy), 32'd0);
    check("startstop_done_state", 32'(r_state), 32'd2);
    start_pulse(2, 0);
    w_stop = 1'b1;
    @(negedge w_clk);
    w_stop = 1'b0;
    check("to_idle_state", 32'(r_state), 32'd0);
    w_start = 1'b1; w_stop = 1'b1; w_div = 8'd1;
    @(negedge w_clk);
    w_start = 1'b0; w_stop = 1'b0;
    check("startstop_idle_busy", 32'(r_busy), 32'd0);
    @(negedge w_clk);
    check("startstop_idle_tick", 32'(r_tick), 32'd0);

    // Start during RUN with a new ratio keeps the original period
    exp_q.delete();
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    start_pulse(4, 0);
    for (int k = 1; k <= 9; k++) begin
      check_tick(k);
      if (k == 2) begin w_start = 1'b1; w_div = 8'd2; end
      if (k == 9) w_stop = 1'b1;
      @(negedge w_clk);
      w_start = 1'b0;
      w_stop  = 1'b0;
    end
    check("restart_ticks_left", 32'(exp_q.size()), 32'd0);
    check("restart_cnt", 32'(r_cnt), 32'd2);
    check("restart_idle", 32'(r_state), 32'd0);

    // Asynchronous reset mid-RUN with ratio 3 and count 5
    exp_q.delete();
    for (int k = 3; k <= 15; k += 3) exp_q.push_back(32'(k));
    start_pulse(3, 0);
    for (int k = 1; k <= 16; k++) begin
      check_tick(k);
      if (k < 16) @(negedge w_clk);
    end
    check("pre_rst_cnt", 32'(r_cnt), 32'd5);
    check("pre_rst_phase", 32'(r_phase), 32'd1);
    #2;
    w_rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(r_cnt), 32'd0);
    check("async_rst_phase", 32'(r_phase), 32'd0);
    check("async_rst_busy", 32'(r_busy), 32'd0);
    check("async_rst_tick", 32'(r_tick), 32'd0);
    check("async_rst_done", 32'(r_done), 32'd0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge w_clk);
      check("post_rst_tick", 32'(r_tick), 32'd0);
      check("post_rst_busy", 32'(r_busy), 32'd0);
    end

`ifdef CLK_CTRL_PAUSE_EN
    // Pause for 7 cycles after the 2nd tick delays the 3rd tick by 7
    exp_q.delete();
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd22);
    exp_q.push_back(32'd27);
    start_pulse(5, 4);
    for (int k = 1; k <= 27; k++) begin
      check_tick(k);
      if (k >= 11 && k <= 18) check("pause_cnt_frozen", 32'(r_cnt), 32'd2);
      w_pause = (k >= 11 && k <= 17);
      @(negedge w_clk);
      w_pause = 1'b0;
    end
    check("pause_ticks_left", 32'(exp_q.size()), 32'd0);
    check("pause_done", 32'(r_done), 32'd1);
    check("pause_cnt", 32'(r_cnt), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
